sme_share_seq: RTL and testbench

- Initiator-side sequencer for the SME share register file.
- MASK op: splits a plain word into SMAX shares, using words from the RNG, and writes them into the share regfile.
- UNMASK op: reads all shares of a logical register through both read ports, XOR-accumulates them, and returns the plain word.
- Sits between the SME execute stage and the share regfile; sole driver of the regfile's read-address and write ports.

---
 rtl/sme_pkg.sv | 19 +
 rtl/sme_share_seq.sv | 147 ++++++++++++++
 tb/tb_sme_share_seq.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sme_pkg.sv
// rtl/sme_pkg.sv - shared types, opcodes and share-address packing for the SME share sequencer
package sme_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MASK   = 2'd1,
        UNMASK = 2'd2,
        RSP    = 2'd3
    } sme_state_t;

    localparam logic SME_OP_MASK   = 1'b0;
    localparam logic SME_OP_UNMASK = 1'b1;

    // Share s of logical register r sits at {s, r} in the share regfile.
    function automatic logic [3:0] share_addr(input logic [1:0] share, input logic [1:0] lreg);
        return {share, lreg};
    endfunction

endpackage

// File: rtl/sme_share_seq.sv
// rtl/sme_share_seq.sv - MASK/UNMASK sequencer for the SME share regfile (option: SME_SHARE_SEQ_ZEROISE_EN)
module sme_share_seq
    import sme_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SMAX = 3
) (
    input  logic            g_clk,
    input  logic            g_reset,
    output logic            g_clk_req,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_op,
    input  logic [1:0]      req_reg,
    input  logic [XLEN-1:0] req_wdata,
    input  logic            rng_valid,
    output logic            rng_ready,
    input  logic [XLEN-1:0] rng_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic [3:0]      rf_rs1_addr,
    input  logic [XLEN-1:0] rf_rs1_rdata,
    output logic [3:0]      rf_rs2_addr,
    input  logic [XLEN-1:0] rf_rs2_rdata,
    output logic            rf_rd_wen,
    output logic [3:0]      rf_rd_addr,
    output logic [XLEN-1:0] rf_rd_wdata
);

    sme_state_t      state;
    logic [2:0]      cnt;
    logic [XLEN-1:0] acc;
    logic            op_q;
    logic [1:0]      reg_q;

    // Last values driven onto the regfile and response buses, held while idle.
    logic [XLEN-1:0] last_wdata;
    logic [3:0]      last_rd_addr;
    logic [3:0]      last_rs1;
    logic [3:0]      last_rs2;
    logic [XLEN-1:0] last_rsp;

    logic            mask_last;
    logic            write_now;
    logic [XLEN-1:0] wr_data;
    logic [3:0]      wr_addr;
    logic [1:0]      cnt_p1;
    logic [3:0]      rs1_live;
    logic [3:0]      rs2_live;
    logic            has_rs2;
    logic [XLEN-1:0] rd_xor;
    logic            unmask_done;
    logic [XLEN-1:0] rsp_live;

    // The final share is the accumulated plain^random residue and needs no RNG word.
    assign mask_last   = (cnt == 3'(SMAX - 1));
    assign write_now   = (state == MASK) && (mask_last || rng_valid);
    assign wr_data     = mask_last ? acc : rng_data;
    assign wr_addr     = share_addr(cnt[1:0], reg_q);
    assign cnt_p1      = cnt[1:0] + 2'd1;
    assign rs1_live    = share_addr(cnt[1:0], reg_q);
    assign rs2_live    = share_addr(cnt_p1, reg_q);
    assign has_rs2     = ((cnt + 3'd1) < 3'(SMAX));
    assign rd_xor      = rf_rs1_rdata ^ (has_rs2 ? rf_rs2_rdata : '0);
    assign unmask_done = ((cnt + 3'd2) >= 3'(SMAX));
    assign rsp_live    = (op_q == SME_OP_UNMASK) ? acc : '0;

    assign req_ready  = (state == IDLE);
    assign g_clk_req  = (state != IDLE) || req_valid;
    assign rng_ready  = (state == MASK) && !mask_last;
    assign rsp_valid  = (state == RSP);
    assign rf_rd_wen  = write_now;
    assign rf_rd_addr = write_now ? wr_addr : last_rd_addr;

`ifdef SME_SHARE_SEQ_ZEROISE_EN
    assign rf_rd_wdata = write_now ? wr_data : '0;
    assign rf_rs1_addr = (state == UNMASK) ? rs1_live : 4'd0;
    assign rf_rs2_addr = (state == UNMASK) ? rs2_live : 4'd0;
    assign rsp_rdata   = (state == RSP) ? rsp_live : '0;
`else
    assign rf_rd_wdata = write_now ? wr_data : last_wdata;
    assign rf_rs1_addr = (state == UNMASK) ? rs1_live : last_rs1;
    assign rf_rs2_addr = (state == UNMASK) ? rs2_live : last_rs2;
    assign rsp_rdata   = (state == RSP) ? rsp_live : last_rsp;
`endif

    // Sequencer FSM with share counter, XOR accumulator and held bus values.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state        <= IDLE;
            cnt          <= '0;
            acc          <= '0;
            op_q         <= 1'b0;
            reg_q        <= '0;
            last_wdata   <= '0;
            last_rd_addr <= '0;
            last_rs1     <= '0;
            last_rs2     <= '0;
            last_rsp     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q  <= req_op;
                        reg_q <= req_reg;
                        cnt   <= '0;
                        acc   <= (req_op == SME_OP_UNMASK) ? '0 : req_wdata;
                        state <= (req_op == SME_OP_UNMASK) ? UNMASK : MASK;
                    end
                end
                MASK: begin
                    if (write_now) begin
                        last_wdata   <= wr_data;
                        last_rd_addr <= wr_addr;
                        if (mask_last) begin
                            state <= RSP;
                        end else begin
                            acc <= acc ^ rng_data;
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                UNMASK: begin
                    last_rs1 <= rs1_live;
                    last_rs2 <= rs2_live;
                    acc      <= acc ^ rd_xor;
                    cnt      <= cnt + 3'd2;
                    if (unmask_done) begin
                        state <= RSP;
                    end
                end
                RSP: begin
                    last_rsp <= rsp_live;
                    if (rsp_ready) begin
                        state <= IDLE;
`ifdef SME_SHARE_SEQ_ZEROISE_EN
                        acc   <= '0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sme_share_seq.sv
// tb/tb_sme_share_seq.sv - randomized self-checking bench for sme_share_seq with a share-level model
module tb_sme_share_seq;

    localparam int XLEN = 32;
    localparam int SMAX = 3;

    logic            g_clk = 1'b0;
    logic            g_reset;
    logic            g_clk_req;
    logic            req_valid;
    logic            req_ready;
    logic            req_op;
    logic [1:0]      req_reg;
    logic [XLEN-1:0] req_wdata;
    logic            rng_valid;
    logic            rng_ready;
    logic [XLEN-1:0] rng_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic [3:0]      rf_rs1_addr;
    logic [XLEN-1:0] rf_rs1_rdata;
    logic [3:0]      rf_rs2_addr;
    logic [XLEN-1:0] rf_rs2_rdata;
    logic            rf_rd_wen;
    logic [3:0]      rf_rd_addr;
    logic [XLEN-1:0] rf_rd_wdata;

    sme_share_seq #(.XLEN(XLEN), .SMAX(SMAX)) dut (
        .g_clk(g_clk), .g_reset(g_reset), .g_clk_req(g_clk_req),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_reg(req_reg), .req_wdata(req_wdata),
        .rng_valid(rng_valid), .rng_ready(rng_ready), .rng_data(rng_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs1_rdata(rf_rs1_rdata),
        .rf_rs2_addr(rf_rs2_addr), .rf_rs2_rdata(rf_rs2_rdata),
        .rf_rd_wen(rf_rd_wen), .rf_rd_addr(rf_rd_addr), .rf_rd_wdata(rf_rd_wdata)
    );

    always #5 g_clk = ~g_clk;

    // Share regfile: combinational reads, posedge writes, no forwarding.
    logic [XLEN-1:0] rf [16];
    assign rf_rs1_rdata = rf[rf_rs1_addr];
    assign rf_rs2_rdata = rf[rf_rs2_addr];
    always @(posedge g_clk) if (rf_rd_wen) rf[rf_rd_addr] <= rf_rd_wdata;

    // Reference model: plain value last masked into each logical register.
    logic [XLEN-1:0] plain [4];
    bit              known [4];
    logic [XLEN-1:0] rng_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic send_req(input logic op, input logic [1:0] r, input logic [XLEN-1:0] w);
        @(negedge g_clk);
        req_valid = 1'b1;
        req_op    = op;
        req_reg   = r;
        req_wdata = w;
        #1;
        check("req_ready_idle", req_ready, 1'b1);
        check("clk_req_on_req", g_clk_req, 1'b1);
        @(posedge g_clk);
    endtask

    // Entered at negedge+1 with rsp_valid high; leaves one cycle into IDLE.
    task automatic finish_rsp(input int hold, input logic [XLEN-1:0] exp);
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            req_valid = 1'b1;
            req_op    = 1'b1;
            #1;
            check("rsp_valid_hold", rsp_valid, 1'b1);
            check("rsp_rdata_hold", rsp_rdata, exp);
            check("req_ready_busy", req_ready, 1'b0);
            check("rng_ready_rsp", rng_ready, 1'b0);
            @(negedge g_clk);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        #1;
        check("rsp_valid_hs", rsp_valid, 1'b1);
        check("rsp_rdata_hs", rsp_rdata, exp);
        check("req_ready_hs", req_ready, 1'b0);
        @(negedge g_clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        #1;
        check("idle_req_ready", req_ready, 1'b1);
        check("idle_rsp_valid", rsp_valid, 1'b0);
        check("idle_wen", rf_rd_wen, 1'b0);
        check("idle_clk_req", g_clk_req, 1'b0);
`ifdef SME_SHARE_SEQ_ZEROISE_EN
        check("zero_wdata", rf_rd_wdata, 0);
        check("zero_rs1", rf_rs1_addr, 0);
        check("zero_rs2", rf_rs2_addr, 0);
        check("zero_rsp", rsp_rdata, 0);
`endif
    endtask

    task automatic do_mask(input logic [1:0] r, input logic [XLEN-1:0] w,
                           input int stall_pct, input int forced, input int hold);
        int k = 0, cyc = 0, stalls = 0, forced_left = forced;
        logic [XLEN-1:0] x = w;
        logic rv;
        send_req(1'b0, r, w);
        while (k < SMAX && cyc < 200) begin
            @(negedge g_clk);
            req_valid = 1'b0;
            if (k == 1 && forced_left > 0) begin
                rv = 1'b0;
                forced_left--;
            end else begin
                rv = ($urandom_range(99) >= stall_pct);
            end
            if (!rv && k < SMAX - 1) stalls++;
            rng_valid = rv;
            rng_data  = (rng_q.size() > 0) ? rng_q[0] : $urandom;
            #1;
            check("rng_ready", rng_ready, (k < SMAX - 1));
            check("rsp_valid_busy", rsp_valid, 1'b0);
            check("mask_wen", rf_rd_wen, (k == SMAX - 1) || rv);
            if (rf_rd_wen) begin
                check("mask_addr", rf_rd_addr, {k[1:0], r});
                check("mask_wdata", rf_rd_wdata, (k < SMAX - 1) ? rng_data : x);
                if (k < SMAX - 1) begin
                    x = x ^ rng_data;
                    if (rng_q.size() > 0) void'(rng_q.pop_front());
                end
                k++;
            end
            cyc++;
        end
        check("mask_timeout", (cyc < 200), 1'b1);
        @(negedge g_clk);
        rng_valid = 1'b0;
        #1;
        check("mask_latency", cyc, SMAX + stalls);
        check("mask_rsp_valid", rsp_valid, 1'b1);
        check("mask_rsp_rdata", rsp_rdata, 0);
        plain[r] = w;
        known[r] = 1'b1;
        finish_rsp(hold, '0);
    endtask

    task automatic do_unmask(input logic [1:0] r, input int hold);
        int c = 0;
        send_req(1'b1, r, $urandom);
        forever begin
            @(negedge g_clk);
            req_valid = 1'b0;
            #1;
            if (rsp_valid || c >= 20) break;
            check("um_rs1", rf_rs1_addr, {2'(2 * c), r});
            if (2 * c + 1 < SMAX) check("um_rs2", rf_rs2_addr, {2'(2 * c + 1), r});
            check("um_wen", rf_rd_wen, 1'b0);
            check("um_rng_ready", rng_ready, 1'b0);
            c++;
        end
        check("um_latency", c, (SMAX + 1) / 2);
        check("um_rsp_valid", rsp_valid, 1'b1);
        check("um_rdata", rsp_rdata, plain[r]);
        finish_rsp(hold, plain[r]);
    endtask

    initial begin
        logic [XLEN-1:0] first_rng;
        logic [1:0] rr;
        for (int i = 0; i < 16; i++) rf[i] = '0;
        for (int i = 0; i < 4; i++) begin plain[i] = '0; known[i] = 1'b0; end
        g_reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_reg = '0; req_wdata = '0;
        rng_valid = 1'b0; rng_data = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge g_clk);
        @(negedge g_clk);
        g_reset = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_wen", rf_rd_wen, 1'b0);
        check("rst_rng_ready", rng_ready, 1'b0);
        check("rst_rd_addr", rf_rd_addr, 0);
        check("rst_rs1", rf_rs1_addr, 0);
        check("rst_rs2", rf_rs2_addr, 0);
        check("rst_wdata", rf_rd_wdata, 0);
        check("rst_clk_req", g_clk_req, 1'b0);

        // Directed MASK with fixed RNG words, then UNMASK of the same register.
        rng_q.push_back(32'h1111_1111);
        rng_q.push_back(32'h2222_2222);
        do_mask(2'd1, 32'hDEAD_BEEF, 0, 0, 0);
        check("dir_rf1", rf[1], 32'h1111_1111);
        check("dir_rf5", rf[5], 32'h2222_2222);
        check("dir_rf9", rf[9], 32'hDEAD_BEEF ^ 32'h1111_1111 ^ 32'h2222_2222);
        do_unmask(2'd1, 0);

        // Three forced RNG stalls mid-op and a held-off response.
        do_mask(2'd2, 32'h0BAD_F00D, 0, 3, 4);
        do_unmask(2'd2, 4);

        // Randomized mix of operations.
        for (int n = 0; n < 30; n++) begin
            rr = 2'($urandom_range(3));
            if (known[rr] && $urandom_range(1) == 1)
                do_unmask(rr, $urandom_range(3));
            else
                do_mask(rr, $urandom, 30, 0, $urandom_range(3));
        end

        // Reset in MASK after one share written.
        send_req(1'b0, 2'd3, 32'hCAFE_0003);
        @(negedge g_clk);
        req_valid = 1'b0;
        rng_valid = 1'b1;
        first_rng = $urandom;
        rng_data  = first_rng;
        #1;
        check("rst_mid_wen", rf_rd_wen, 1'b1);
        @(negedge g_clk);
        g_reset = 1'b1;
        @(negedge g_clk);
        g_reset = 1'b0;
        rng_valid = 1'b0;
        #1;
        check("abort_req_ready", req_ready, 1'b1);
        check("abort_rsp_valid", rsp_valid, 1'b0);
        check("abort_wen", rf_rd_wen, 1'b0);
        check("abort_rng_ready", rng_ready, 1'b0);
        check("abort_partial_share", rf[4'h3], first_rng);
        known[3] = 1'b0;

        do_mask(2'd0, 32'h1234_5678, 20, 0, 1);
        do_unmask(2'd0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=%0d", n_checks, 0);
        $fatal(1);
    end

endmodule
